// File: rtl/inst_fetch_if.sv
// ============================================================================
// Module      : inst_fetch_if
// Description : Instruction-fetch responder between the PC register and the
//               instruction-side SRAM-like bus. Runs one request/addr_ok/
//               data_ok transaction at a time, holds a stall request while the
//               word is outstanding, presents the word to IF/ID and discards
//               responses made stale by a pipeline flush.
// Optional    : INST_FETCH_ALIGN_CHECK_EN - when defined, a misaligned fetch
//               address in IDLE raises excepttype_o[ADEL_IDX] and issues no
//               bus request.
// Ports       : clk, rst (async, active-high)
//               pc_i, ce_i            - fetch address / enable from PC reg
//               stall, flush          - IF-stage stall / flush from CTRL
//               inst_o, excepttype_o  - word and exception flags to IF/ID
//               stallreq_o            - stall request to CTRL
//               inst_req_o, inst_addr_o, inst_addr_ok_i,
//               inst_data_ok_i, inst_rdata_i - instruction bus
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_if #(
    parameter int          ADEL_IDX = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] inst_o,
    output logic        stallreq_o,
    output logic [31:0] excepttype_o,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [31:0] c_ADEL_MASK = 32'd1 << ADEL_IDX;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic        r_drop;
    logic        w_drop_nxt;
    logic [31:0] r_ibuf;
    logic [31:0] w_ibuf_nxt;
    logic        w_misal;
    logic        w_issue;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_stallreq;
    logic [31:0] w_inst;
    logic [31:0] w_exc;

`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign w_misal = ce_i && (pc_i[1:0] != 2'b00);
`else
    assign w_misal = 1'b0;
`endif

    // A fresh request can only start from IDLE; flush suppresses it so the
    // redirected PC is fetched on the following cycle instead.
    assign w_issue = (r_state == S_IDLE) && ce_i && !flush && !w_misal;

    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        w_ibuf_nxt  = r_ibuf;
        w_req       = 1'b0;
        w_addr      = r_addr;
        w_stallreq  = 1'b0;
        w_inst      = NOP_INST;
        w_exc       = 32'd0;
        case (r_state)
            S_IDLE: begin
                w_req      = w_issue;
                w_addr     = pc_i;
                w_stallreq = w_issue;
                if (w_misal && (r_state == S_IDLE)) begin
                    w_exc = c_ADEL_MASK;
                end
                if (w_issue) begin
                    w_state_nxt = inst_addr_ok_i ? S_DATA : S_ADDR;
                end
            end
            S_ADDR: begin
                // The request is never withdrawn once raised.
                w_req      = 1'b1;
                w_stallreq = 1'b1;
                if (flush) begin
                    w_drop_nxt = 1'b1;
                end
                if (inst_addr_ok_i) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (inst_data_ok_i) begin
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                    if (!r_drop && !flush) begin
                        w_inst = inst_rdata_i;
                        // IF/ID is frozen: park the word until it can be taken.
                        if (stall) begin
                            w_ibuf_nxt  = inst_rdata_i;
                            w_state_nxt = S_HOLD;
                        end
                    end
                end else begin
                    w_stallreq = 1'b1;
                    if (flush) begin
                        w_drop_nxt = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                w_inst = r_ibuf;
                if (flush) begin
                    w_ibuf_nxt  = 32'd0;
                    w_state_nxt = S_IDLE;
                end else if (!stall) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= 32'd0;
            r_drop  <= 1'b0;
            r_ibuf  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            r_ibuf  <= w_ibuf_nxt;
            if (w_issue) begin
                r_addr <= pc_i;
            end
        end
    end

    // IDLE outputs follow the inputs combinationally, so gate them by reset.
    assign inst_req_o   = w_req & ~rst;
    assign stallreq_o   = w_stallreq & ~rst;
    assign inst_addr_o  = rst ? 32'd0 : w_addr;
    assign inst_o       = rst ? NOP_INST : w_inst;
    assign excepttype_o = rst ? 32'd0 : w_exc;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_if.sv
`default_nettype none

module tb_inst_fetch_if;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        stall;
    logic        flush;
    logic [31:0] inst_o;
    logic        stallreq_o;
    logic [31:0] excepttype_o;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;

    int total;
    int bad;

    inst_fetch_if dut (
        .clk            (clk),
        .rst            (rst),
        .pc_i           (pc_i),
        .ce_i           (ce_i),
        .stall          (stall),
        .flush          (flush),
        .inst_o         (inst_o),
        .stallreq_o     (stallreq_o),
        .excepttype_o   (excepttype_o),
        .inst_req_o     (inst_req_o),
        .inst_addr_o    (inst_addr_o),
        .inst_addr_ok_i (inst_addr_ok_i),
        .inst_data_ok_i (inst_data_ok_i),
        .inst_rdata_i   (inst_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic        stl;
        logic        fl;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_sreq;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ce, input logic [31:0] pc, input logic stl,
                         input logic fl, input logic aok, input logic dok,
                         input logic [31:0] rd);
        ce_i = ce; pc_i = pc; stall = stl; flush = fl;
        inst_addr_ok_i = aok; inst_data_ok_i = dok; inst_rdata_i = rd;
    endtask

    function automatic vec_t mk(input logic ce, input logic [31:0] pc, input logic stl,
                                input logic fl, input logic aok, input logic dok,
                                input logic [31:0] rd, input logic er,
                                input logic [31:0] ea, input logic es,
                                input logic [31:0] ei);
        vec_t v;
        v.ce = ce; v.pc = pc; v.stl = stl; v.fl = fl; v.aok = aok; v.dok = dok;
        v.rdata = rd; v.e_req = er; v.e_addr = ea; v.e_sreq = es; v.e_inst = ei;
        return v;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        //             ce pc            stl fl aok dok rdata         req addr          sreq inst
        vecs[0]  = mk(0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
        vecs[1]  = mk(0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
        // best case: addr_ok with request, data_ok next cycle
        vecs[2]  = mk(1, 32'hBFC00000, 0, 0, 1, 0, 32'h0,        1, 32'hBFC00000, 1, 32'h0);
        vecs[3]  = mk(1, 32'hBFC00000, 0, 0, 0, 1, 32'h3C011234, 0, 32'h0,        0, 32'h3C011234);
        // addr_ok delayed 3 cycles, data_ok 2 later; pc_i garbled to prove latch
        vecs[4]  = mk(1, 32'hBFC00004, 0, 0, 0, 0, 32'h0,        1, 32'hBFC00004, 1, 32'h0);
        vecs[5]  = mk(1, 32'h12345678, 0, 0, 0, 0, 32'h0,        1, 32'hBFC00004, 1, 32'h0);
        vecs[6]  = mk(1, 32'h12345678, 0, 0, 0, 0, 32'h0,        1, 32'hBFC00004, 1, 32'h0);
        vecs[7]  = mk(1, 32'h12345678, 0, 0, 1, 0, 32'h0,        1, 32'hBFC00004, 1, 32'h0);
        vecs[8]  = mk(1, 32'hBFC00004, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0);
        vecs[9]  = mk(1, 32'hBFC00004, 0, 0, 0, 1, 32'h8C020010, 0, 32'h0,        0, 32'h8C020010);
        // flush in DATA two cycles before data_ok
        vecs[10] = mk(1, 32'hBFC00008, 0, 0, 1, 0, 32'h0,        1, 32'hBFC00008, 1, 32'h0);
        vecs[11] = mk(1, 32'hBFC00008, 0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0);
        vecs[12] = mk(1, 32'hBFC00380, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0);
        vecs[13] = mk(1, 32'hBFC00380, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
        vecs[14] = mk(1, 32'hBFC00380, 0, 0, 1, 0, 32'h0,        1, 32'hBFC00380, 1, 32'h0);
        // flush coincident with data_ok, then flush in IDLE
        vecs[15] = mk(1, 32'hBFC00380, 0, 1, 0, 1, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
        vecs[16] = mk(1, 32'hBFC00380, 0, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0);
        vecs[17] = mk(1, 32'hBFC00380, 0, 0, 1, 0, 32'h0,        1, 32'hBFC00380, 1, 32'h0);
        // stall during data_ok and 3 more cycles -> HOLD
        vecs[18] = mk(1, 32'hBFC00380, 1, 0, 0, 1, 32'h24420001, 0, 32'h0,        0, 32'h24420001);
        vecs[19] = mk(1, 32'hBFC00380, 1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h24420001);
        vecs[20] = mk(1, 32'hBFC00380, 1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h24420001);
        vecs[21] = mk(1, 32'hBFC00380, 1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h24420001);
        vecs[22] = mk(1, 32'hBFC00380, 0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h24420001);
        // new request left un-accepted, abandoned by the reset below
        vecs[23] = mk(1, 32'hBFC00384, 0, 0, 0, 0, 32'h0,        1, 32'hBFC00384, 1, 32'h0);

        // reset state while inputs request a fetch
        rst = 1'b1;
        drive(1, 32'hBFC00000, 0, 0, 1, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   {31'd0, inst_req_o}, 32'd0);
        chk("rst_sreq",  {31'd0, stallreq_o}, 32'd0);
        chk("rst_inst",  inst_o, 32'd0);
        chk("rst_exc",   excepttype_o, 32'd0);
        chk("rst_addr",  inst_addr_o, 32'd0);

        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].ce, vecs[i].pc, vecs[i].stl, vecs[i].fl,
                  vecs[i].aok, vecs[i].dok, vecs[i].rdata);
            @(negedge clk);
            chk($sformatf("v%0d_req", i),  {31'd0, inst_req_o}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d_sreq", i), {31'd0, stallreq_o}, {31'd0, vecs[i].e_sreq});
            chk($sformatf("v%0d_inst", i), inst_o, vecs[i].e_inst);
            chk($sformatf("v%0d_exc", i),  excepttype_o, 32'd0);
            if (vecs[i].e_req)
                chk($sformatf("v%0d_addr", i), inst_addr_o, vecs[i].e_addr);
            @(posedge clk); #1;
        end

        // asynchronous reset in mid-transaction (DUT is in ADDR here)
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_req",  {31'd0, inst_req_o}, 32'd0);
        chk("mid_rst_sreq", {31'd0, stallreq_o}, 32'd0);
        chk("mid_rst_addr", inst_addr_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 32'h0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk("post_rst_req",  {31'd0, inst_req_o}, 32'd0);
        chk("post_rst_sreq", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk); #1;
        // state must be IDLE: address follows pc_i, not the abandoned one
        drive(1, 32'hBFC00010, 0, 0, 1, 0, 32'h0);
        @(negedge clk);
        chk("post_rst_fetch_req",  {31'd0, inst_req_o}, 32'd1);
        chk("post_rst_fetch_addr", inst_addr_o, 32'hBFC00010);
        @(posedge clk); #1;
        drive(1, 32'hBFC00010, 0, 0, 0, 1, 32'h11112222);
        @(negedge clk);
        chk("post_rst_fetch_inst", inst_o, 32'h11112222);
        chk("post_rst_fetch_sreq", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk); #1;

        // misaligned fetch address
        drive(1, 32'hBFC00002, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
`ifdef INST_FETCH_ALIGN_CHECK_EN
        chk("misal_req",  {31'd0, inst_req_o}, 32'd0);
        chk("misal_sreq", {31'd0, stallreq_o}, 32'd0);
        chk("misal_exc",  excepttype_o, 32'h0000_0010);
        chk("misal_inst", inst_o, 32'd0);
        @(posedge clk); #1;
        drive(0, 32'hBFC00002, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk("misal_after_exc", excepttype_o, 32'd0);
`else
        chk("misal_req",  {31'd0, inst_req_o}, 32'd1);
        chk("misal_addr", inst_addr_o, 32'hBFC00002);
        chk("misal_sreq", {31'd0, stallreq_o}, 32'd1);
        chk("misal_exc",  excepttype_o, 32'd0);
        chk("misal_inst", inst_o, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
